ctrl_cfg_decoder: RTL and testbench

- Sits directly downstream of the control branch of the packet filter.
- Consumes the control-packet AXI-Stream, which has no back-pressure.
- Decodes each control packet into one table-write command and buffers commands in a small FIFO toward the pipeline-stage configuration port, which has a valid/ready handshake.
- Drops packets addressed to another module, malformed packets and packets that overflow the buffer.

---
 rtl/ctrl_cfg_decoder_pkg.sv | 27 ++
 rtl/ctrl_cfg_decoder_fifo.sv | 63 ++++++
 rtl/ctrl_cfg_decoder.sv | 155 +++++++++++++++
 tb/tb_ctrl_cfg_decoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_cfg_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_cfg_decoder_pkg
// Shared definitions for the control-packet configuration decoder:
//   - bit offsets of the header fields inside the stream data word
//   - decoder state encoding
//   - command key {resource, index}. The full command type is
//     {key, data} and is declared in the top, because its data width
//     is a module parameter.
// ---------------------------------------------------------------------------
package ctrl_cfg_decoder_pkg;

   localparam int MOD_ID_LSB = 336;
   localparam int RES_ID_LSB = 344;
   localparam int IDX_LSB    = 352;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      DISCARD   = 2'd2
   } dec_state_t;

   typedef struct packed {
      logic [7:0]  resource;
      logic [15:0] index;
   } cfg_key_t;

endpackage

// File: rtl/ctrl_cfg_decoder_fifo.sv
// ---------------------------------------------------------------------------
// cfg_cmd_fifo
// Synchronous show-ahead FIFO. The head entry is visible on rd_data
// whenever empty=0, and it advances on rd_en && !empty. A write into a full
// FIFO is accepted only when a read happens in the same cycle. Otherwise the
// write is ignored, and the parent counts it as an overflow.
// Ports:
//   clk, areset       clock, asynchronous active-high reset
//   wr_en, wr_data    write request / entry
//   rd_en             consume head entry
//   rd_data           head entry (combinational read for show-ahead)
//   full, empty       occupancy flags
// ---------------------------------------------------------------------------
module cfg_cmd_fifo
   import ctrl_cfg_decoder_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         areset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   // The extra pointer MSB separates full (MSBs differ) from empty (equal).
   logic [AW:0]  wr_ptr_reg, rd_ptr_reg;
   logic [W-1:0] mem [DEPTH];
   logic         push, pop;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop   = rd_en & ~empty;
   // When the FIFO is full and a pop happens in the same cycle, the write
   // lands in the slot that is being freed.
   assign push  = wr_en & (~full | pop);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
   end

   // The head is read combinationally so that a command written at one edge
   // is presented immediately after that edge.
   assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/ctrl_cfg_decoder.sv
// ---------------------------------------------------------------------------
// ctrl_cfg_decoder
// Decodes control packets (header beat + data beat) from a stream that has
// no back-pressure into table-write commands. The commands are buffered in
// a small show-ahead FIFO toward a valid/ready configuration port. The
// decoder drops packets for other modules, short packets and commands that
// overflow the buffer.
// Build option: define CFG_ERR_CNT_EN to build the error counters.
// Without it, err_short_cnt and err_ovf_cnt read 0.
// Ports:
//   clk, areset                 clock, asynchronous active-high reset
//   c_s_axis_*                  control stream in (tkeep/tuser ignored)
//   cfg_wr_valid/ready          command handshake
//   cfg_wr_resource/index/data  head command fields (0 while empty)
//   err_short_cnt               packets that end on their header beat
//   err_ovf_cnt                 commands dropped on a full FIFO
// ---------------------------------------------------------------------------
module ctrl_cfg_decoder
   import ctrl_cfg_decoder_pkg::*;
#(
   parameter int         C_S_AXIS_DATA_WIDTH  = 512,
   parameter int         C_S_AXIS_TUSER_WIDTH = 128,
   parameter int         C_CFG_DATA_WIDTH     = 256,
   parameter logic [7:0] C_MODULE_ID          = 8'h00,
   parameter int         C_FIFO_DEPTH         = 4
) (
   input  logic                              clk,
   input  logic                              areset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
   input  logic                              c_s_axis_tvalid,
   input  logic                              c_s_axis_tlast,
   output logic                              cfg_wr_valid,
   input  logic                              cfg_wr_ready,
   output logic [7:0]                        cfg_wr_resource,
   output logic [15:0]                       cfg_wr_index,
   output logic [C_CFG_DATA_WIDTH-1:0]       cfg_wr_data,
   output logic [31:0]                       err_short_cnt,
   output logic [31:0]                       err_ovf_cnt
);

   typedef struct packed {
      cfg_key_t                    key;
      logic [C_CFG_DATA_WIDTH-1:0] data;
   } cmd_t;

   dec_state_t state_reg, state_next;
   cfg_key_t   key_reg, key_next;
   cfg_key_t   hdr_key;
   logic [7:0] hdr_mod;
   logic       push, short_evt, ovf_evt, pop;
   logic       fifo_full, fifo_empty;
   cmd_t       push_cmd, head_cmd;

   // Only part of tdata is used, and tkeep/tuser are not used at all.
   logic unused_in;
   assign unused_in = ^{c_s_axis_tkeep, c_s_axis_tuser, c_s_axis_tdata};

   assign hdr_mod          = c_s_axis_tdata[MOD_ID_LSB +: 8];
   assign hdr_key.resource = c_s_axis_tdata[RES_ID_LSB +: 8];
   assign hdr_key.index    = c_s_axis_tdata[IDX_LSB +: 16];

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_reg <= IDLE;
         key_reg   <= '0;
      end else begin
         state_reg <= state_next;
         key_reg   <= key_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      key_next   = key_reg;
      push       = 1'b0;
      short_evt  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (c_s_axis_tvalid) begin
               if (c_s_axis_tlast) begin
                  // Any single-beat packet is short, whatever it addresses.
                  short_evt = 1'b1;
               end else if (hdr_mod != C_MODULE_ID) begin
                  state_next = DISCARD;
               end else begin
                  key_next   = hdr_key;
                  state_next = WAIT_DATA;
               end
            end
         end
         WAIT_DATA: begin
            if (c_s_axis_tvalid) begin
               push       = 1'b1;
               state_next = c_s_axis_tlast ? IDLE : DISCARD;
            end
         end
         DISCARD: begin
            if (c_s_axis_tvalid && c_s_axis_tlast) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign push_cmd.key  = key_reg;
   assign push_cmd.data = c_s_axis_tdata[C_CFG_DATA_WIDTH-1:0];

   cfg_cmd_fifo #(
      .W     ($bits(cmd_t)),
      .DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .areset  (areset),
      .wr_en   (push),
      .wr_data (push_cmd),
      .rd_en   (cfg_wr_ready),
      .rd_data (head_cmd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign pop     = ~fifo_empty & cfg_wr_ready;
   assign ovf_evt = push & fifo_full & ~pop;

   // The FIFO storage is not reset, so the outputs are forced to zero while
   // no command is held.
   assign cfg_wr_valid    = ~fifo_empty;
   assign cfg_wr_resource = fifo_empty ? '0 : head_cmd.key.resource;
   assign cfg_wr_index    = fifo_empty ? '0 : head_cmd.key.index;
   assign cfg_wr_data     = fifo_empty ? '0 : head_cmd.data;

`ifdef CFG_ERR_CNT_EN
   logic [31:0] short_cnt_reg, ovf_cnt_reg;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         short_cnt_reg <= '0;
         ovf_cnt_reg   <= '0;
      end else begin
         if (short_evt) short_cnt_reg <= short_cnt_reg + 32'd1;
         if (ovf_evt)   ovf_cnt_reg   <= ovf_cnt_reg + 32'd1;
      end
   end

   assign err_short_cnt = short_cnt_reg;
   assign err_ovf_cnt   = ovf_cnt_reg;
`else
   logic unused_evt;
   assign unused_evt    = short_evt ^ ovf_evt;
   assign err_short_cnt = '0;
   assign err_ovf_cnt   = '0;
`endif

endmodule

// File: tb/tb_ctrl_cfg_decoder.sv
// ---------------------------------------------------------------------------
// tb_ctrl_cfg_decoder
// Directed scenarios plus randomized packets for ctrl_cfg_decoder. A
// packet-level model counts the beats within each packet and keeps a queue
// of pending commands. The DUT outputs are compared with that model on
// every falling edge. Literal expectations pin the directed scenarios.
// ---------------------------------------------------------------------------
module tb_ctrl_cfg_decoder;

   localparam int DW    = 512;
   localparam int CW    = 256;
   localparam int DEPTH = 4;
`ifdef CFG_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           areset;
   logic [DW-1:0]  tdata;
   logic [DW/8-1:0] tkeep;
   logic [127:0]   tuser;
   logic           tvalid, tlast;
   logic           cfg_wr_valid, cfg_wr_ready;
   logic [7:0]     cfg_wr_resource;
   logic [15:0]    cfg_wr_index;
   logic [CW-1:0]  cfg_wr_data;
   logic [31:0]    err_short_cnt, err_ovf_cnt;

   bit rand_rdy  = 1'b0;
   bit rdy_rand  = 1'b0;
   bit rdy_force = 1'b1;
   assign cfg_wr_ready = rand_rdy ? rdy_rand : rdy_force;

   always #5 clk = ~clk;

   ctrl_cfg_decoder dut (
      .clk             (clk),
      .areset          (areset),
      .c_s_axis_tdata  (tdata),
      .c_s_axis_tkeep  (tkeep),
      .c_s_axis_tuser  (tuser),
      .c_s_axis_tvalid (tvalid),
      .c_s_axis_tlast  (tlast),
      .cfg_wr_valid    (cfg_wr_valid),
      .cfg_wr_ready    (cfg_wr_ready),
      .cfg_wr_resource (cfg_wr_resource),
      .cfg_wr_index    (cfg_wr_index),
      .cfg_wr_data     (cfg_wr_data),
      .err_short_cnt   (err_short_cnt),
      .err_ovf_cnt     (err_ovf_cnt)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0]   r;
      logic [15:0]  i;
      logic [255:0] d;
   } mcmd_t;

   mcmd_t       mq[$];
   int          m_beat  = 0;
   bit          m_pend  = 1'b0;
   logic [7:0]  m_r     = '0;
   logic [15:0] m_i     = '0;
   int unsigned m_short = 0;
   int unsigned m_ovf   = 0;

   always @(posedge clk or posedge areset) begin
      bit    do_pop;
      mcmd_t c;
      if (areset) begin
         mq.delete();
         m_beat  = 0;
         m_pend  = 1'b0;
         m_short = 0;
         m_ovf   = 0;
      end else begin
         do_pop = (mq.size() > 0) && cfg_wr_ready;
         if (do_pop) void'(mq.pop_front());
         if (tvalid) begin
            if (m_beat == 0) begin
               m_pend = 1'b0;
               if (tlast) m_short++;
               else if (tdata[343:336] == 8'h00) begin
                  m_pend = 1'b1;
                  m_r    = tdata[351:344];
                  m_i    = tdata[367:352];
               end
            end else if (m_beat == 1 && m_pend) begin
               c.r = m_r;
               c.i = m_i;
               c.d = tdata[255:0];
               if (mq.size() < DEPTH) mq.push_back(c);
               else m_ovf++;
            end
            m_beat = tlast ? 0 : m_beat + 1;
         end
      end
   end

   always @(negedge clk) begin
      chk("valid", cfg_wr_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("resource", cfg_wr_resource, mq[0].r);
         chk("index", cfg_wr_index, mq[0].i);
         chk("data", cfg_wr_data, mq[0].d);
      end
      chk("short_cnt", err_short_cnt, CNT_EN ? m_short : 0);
      chk("ovf_cnt", err_ovf_cnt, CNT_EN ? m_ovf : 0);
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rdy_rand = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [DW-1:0] rnd512();
      logic [DW-1:0] d;
      for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [DW-1:0] hdr(input logic [7:0] md, input logic [7:0] rs, input logic [15:0] ix);
      logic [DW-1:0] d;
      d = rnd512();
      d[343:336] = md;
      d[351:344] = rs;
      d[367:352] = ix;
      return d;
   endfunction

   function automatic logic [DW-1:0] dat(input logic [255:0] v);
      logic [DW-1:0] d;
      d = rnd512();
      d[255:0] = v;
      return d;
   endfunction

   task automatic beat(input logic [DW-1:0] d, input logic last);
      tdata  = d;
      tlast  = last;
      tvalid = 1'b1;
      tuser  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      tlast  = 1'($urandom_range(0, 1));
      tdata  = rnd512();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int len;
      logic [7:0] md;
      areset = 1'b1;
      tvalid = 1'b0;
      tlast  = 1'b0;
      tdata  = '0;
      tkeep  = '1;
      tuser  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", cfg_wr_valid, 0);
      chk("rst_resource", cfg_wr_resource, 0);
      chk("rst_index", cfg_wr_index, 0);
      chk("rst_data", cfg_wr_data, 0);
      chk("rst_short", err_short_cnt, 0);
      chk("rst_ovf", err_ovf_cnt, 0);
      areset = 1'b0;
      idle(1);

      // Basic decode: the command appears right after the data beat.
      rdy_force = 1'b1;
      beat(hdr(8'h00, 8'h05, 16'h0012), 1'b0);
      chk("t1_no_early", cfg_wr_valid, 0);
      beat(dat(256'hABCD), 1'b1);
      chk("t1_valid", cfg_wr_valid, 1);
      chk("t1_res", cfg_wr_resource, 8'h05);
      chk("t1_idx", cfg_wr_index, 16'h0012);
      chk("t1_data", cfg_wr_data, 256'hABCD);
      idle(1);
      chk("t1_single", cfg_wr_valid, 0);

      // Other module, then a normal packet.
      beat(hdr(8'h03, 8'h11, 16'h2222), 1'b0);
      beat(rnd512(), 1'b0);
      beat(rnd512(), 1'b1);
      chk("t2_dropped", cfg_wr_valid, 0);
      chk("t2_short", err_short_cnt, 0);
      chk("t2_ovf", err_ovf_cnt, 0);
      beat(hdr(8'h00, 8'h21, 16'h0100), 1'b0);
      beat(dat(256'h1234), 1'b1);
      chk("t2_res", cfg_wr_resource, 8'h21);
      chk("t2_data", cfg_wr_data, 256'h1234);
      idle(1);

      // Single-beat packet.
      beat(hdr(8'h00, 8'h06, 16'h0007), 1'b1);
      chk("t3_short", err_short_cnt, CNT_EN ? 1 : 0);
      chk("t3_valid", cfg_wr_valid, 0);

      // Overflow: six packets into depth 4 while stalled.
      rdy_force = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         beat(hdr(8'h00, 8'(k), 16'(k * 16)), 1'b0);
         beat(dat(256'(k * 100)), 1'b1);
      end
      chk("t4_ovf", err_ovf_cnt, CNT_EN ? 2 : 0);
      chk("t4_valid", cfg_wr_valid, 1);
      rdy_force = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("t4_drain_res", cfg_wr_resource, 8'(k));
         chk("t4_drain_data", cfg_wr_data, 256'(k * 100));
         idle(1);
      end
      chk("t4_empty", cfg_wr_valid, 0);

      // Gaps inside a packet plus extra trailing beats.
      rdy_force = 1'b0;
      beat(hdr(8'h00, 8'h44, 16'hBEEF), 1'b0);
      idle(3);
      beat(dat(256'h5555), 1'b0);
      idle(2);
      beat(rnd512(), 1'b0);
      beat(rnd512(), 1'b1);
      chk("t5_valid", cfg_wr_valid, 1);
      chk("t5_res", cfg_wr_resource, 8'h44);
      chk("t5_idx", cfg_wr_index, 16'hBEEF);
      chk("t5_data", cfg_wr_data, 256'h5555);
      rdy_force = 1'b1;
      idle(1);
      chk("t5_one_cmd", cfg_wr_valid, 0);

      // Reset between header and data beat.
      chk("t6_pre_short", err_short_cnt, CNT_EN ? 1 : 0);
      chk("t6_pre_ovf", err_ovf_cnt, CNT_EN ? 2 : 0);
      rdy_force = 1'b0;
      beat(hdr(8'h00, 8'h07, 16'h0001), 1'b0);
      beat(dat(256'd77), 1'b1);
      beat(hdr(8'h00, 8'h09, 16'h0002), 1'b0);
      areset = 1'b1;
      #1;
      chk("t6_rst_valid", cfg_wr_valid, 0);
      chk("t6_rst_res", cfg_wr_resource, 0);
      chk("t6_rst_short", err_short_cnt, 0);
      chk("t6_rst_ovf", err_ovf_cnt, 0);
      @(posedge clk);
      #1;
      areset = 1'b0;
      beat(hdr(8'h00, 8'h0A, 16'h0033), 1'b0);
      chk("t6_hdr_only", cfg_wr_valid, 0);
      beat(dat(256'h99), 1'b1);
      chk("t6_valid", cfg_wr_valid, 1);
      chk("t6_res", cfg_wr_resource, 8'h0A);
      chk("t6_idx", cfg_wr_index, 16'h0033);
      chk("t6_data", cfg_wr_data, 256'h99);
      rdy_force = 1'b1;
      idle(1);

      // Randomized packets with random ready.
      rand_rdy = 1'b1;
      for (int p = 0; p < 300; p++) begin
         len = $urandom_range(1, 4);
         md  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         for (int b = 0; b < len; b++) begin
            if (b == 0) beat(hdr(md, 8'($urandom), 16'($urandom)), 1'(len == 1));
            else        beat(dat({8{$urandom}}), 1'(b == len - 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      rand_rdy  = 1'b0;
      rdy_force = 1'b1;
      idle(DEPTH + 4);
      chk("final_empty", cfg_wr_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
